spi_frame_regs: RTL and testbench

- Parametrised SPI mode-0 slave framer; next generation of the per-byte SPI register decode in the stepper CPLD.
- Moves N_WORDS words each way per SSEL frame, then one checksum byte.
- TX data is snapshotted at frame start, so all positions come from the same instant.
- RX data is double-buffered and committed atomically at frame end, only if length and checksum are correct.

---
 rtl/spi_frame_regs.sv | 161 ++++++++++++++++
 tb/tb_spi_frame_regs.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_regs.sv
// SPI mode-0 slave framer: N_WORDS words each way per SSEL frame plus an XOR checksum byte.
// TX words are snapshotted at frame start; RX words commit atomically only on a clean frame.
module spi_frame_regs #(
  parameter int N_WORDS = 5,
  parameter int WB      = 4,
  parameter int CNT_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sck,
  input  logic                      ssel,
  input  logic                      mosi,
  output logic                      miso,
  input  logic [N_WORDS*WB*8-1:0]   tx_data,
  output logic                      tx_snap,
  output logic [N_WORDS*WB*8-1:0]   rx_data,
  output logic                      rx_valid,
  output logic                      frame_err,
  output logic [CNT_W-1:0]          err_cnt,
  output logic                      busy
);

  localparam int NB   = N_WORDS * WB;
  localparam int FB   = NB + 1;
  localparam int BC_W = ($clog2(FB + 2) > 5) ? $clog2(FB + 2) : 5;
  localparam int IW   = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BC_W-1:0] LAST = BC_W'(FB - 1);
  localparam logic [BC_W-1:0] FULL = BC_W'(FB);

  logic [2:0]      sck_s, ssel_s, mosi_s;
  logic            sck_rise, sck_fall;
  logic            ssel_fall, ssel_rise;

  logic [7:0]      shadow  [NB];
  logic [7:0]      staging [NB];
  logic [7:0]      rxsr, txsr;
  logic [7:0]      rx_sum, tx_sum, rx_chk;
  logic [2:0]      bitcnt;
  logic [BC_W-1:0] bytecnt;
  logic            active;
  logic            pend_ok, pend_bad;

  logic [7:0]      rx_byte;
  logic [7:0]      next_tx;
  logic [IW-1:0]   bidx;
  logic            accept;

  // SSEL chain resets low so a select held low through reset release is not seen as a start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_s  <= '0;
      ssel_s <= '0;
      mosi_s <= '0;
    end else begin
      sck_s  <= {sck_s[1:0], sck};
      ssel_s <= {ssel_s[1:0], ssel};
      mosi_s <= {mosi_s[1:0], mosi};
    end
  end

  assign sck_rise  =  sck_s[1] & ~sck_s[2];
  assign sck_fall  = ~sck_s[1] &  sck_s[2];
  assign ssel_fall = ~ssel_s[1] &  ssel_s[2];
  assign ssel_rise =  ssel_s[1] & ~ssel_s[2];

  assign rx_byte = {rxsr[6:0], mosi_s[1]};
  assign bidx    = bytecnt[IW-1:0];
  assign accept  = (bytecnt == FULL) && (bitcnt == 3'd0)
                && (rx_chk == rx_sum);

  always_comb begin
    next_tx = 8'h00;
    if (bytecnt < LAST)
      next_tx = shadow[bidx];
    else if (bytecnt == LAST)
      next_tx = tx_sum;
  end

  assign miso = active & txsr[7];
  assign busy = active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NB; i++) begin
        shadow[i]  <= '0;
        staging[i] <= '0;
      end
      rxsr      <= '0;
      txsr      <= '0;
      rx_sum    <= '0;
      tx_sum    <= '0;
      rx_chk    <= '0;
      bitcnt    <= '0;
      bytecnt   <= '0;
      active    <= 1'b0;
      pend_ok   <= 1'b0;
      pend_bad  <= 1'b0;
      tx_snap   <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      err_cnt   <= '0;
    end else begin
      tx_snap   <= 1'b0;
      rx_valid  <= pend_ok;
      frame_err <= pend_bad;
      pend_ok   <= 1'b0;
      pend_bad  <= 1'b0;

      if (pend_ok) begin
        for (int i = 0; i < NB; i++)
          rx_data[8*i +: 8] <= staging[i];
      end
      if (pend_bad && (err_cnt != '1))
        err_cnt <= err_cnt + 1'b1;

      if (ssel_fall) begin
        for (int i = 0; i < NB; i++)
          shadow[i] <= tx_data[8*i +: 8];
        tx_snap <= 1'b1;
        bitcnt  <= '0;
        bytecnt <= '0;
        rx_sum  <= '0;
        // Byte 0 goes out immediately, so it is folded into the checksum here.
        tx_sum  <= tx_data[7:0];
        txsr    <= tx_data[7:0];
        active  <= 1'b1;
      end else if (ssel_rise && active) begin
        active <= 1'b0;
        if (accept)
          pend_ok <= 1'b1;
        else
          pend_bad <= 1'b1;
      end else if (active) begin
        if (sck_rise) begin
          rxsr   <= rx_byte;
          bitcnt <= bitcnt + 3'd1;
          if (bitcnt == 3'd7) begin
            if (bytecnt < LAST) begin
              staging[bidx] <= rx_byte;
              rx_sum        <= rx_sum ^ rx_byte;
            end else if (bytecnt == LAST) begin
              rx_chk <= rx_byte;
            end
            if (bytecnt != '1)
              bytecnt <= bytecnt + 1'b1;
          end
        end else if (sck_fall) begin
          if (bitcnt == 3'd0) begin
            txsr <= next_tx;
            if (bytecnt < LAST)
              tx_sum <= tx_sum ^ next_tx;
          end else begin
            txsr <= {txsr[6:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_regs.sv
// Bench for spi_frame_regs: queued MISO/RX expectations, framing errors,
// snapshot, reset abort and error-counter saturation.
module tb_spi_frame_regs;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n, sck, mosi, ssel_a, ssel_b;
  logic [DW-1:0] tx_data;

  logic          miso_a, tx_snap_a, rx_valid_a, frame_err_a, busy_a;
  logic [DW-1:0] rx_data_a;
  logic [7:0]    err_cnt_a;
  logic          miso_b, tx_snap_b, rx_valid_b, frame_err_b, busy_b;
  logic [DW-1:0] rx_data_b;
  logic [1:0]    err_cnt_b;

  always #5 clk = ~clk;

  spi_frame_regs #(.N_WORDS(2), .WB(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .sck(sck), .ssel(ssel_a), .mosi(mosi),
    .miso(miso_a), .tx_data(tx_data), .tx_snap(tx_snap_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .frame_err(frame_err_a),
    .err_cnt(err_cnt_a), .busy(busy_a)
  );

  spi_frame_regs #(.N_WORDS(2), .WB(4), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .sck(sck), .ssel(ssel_b), .mosi(mosi),
    .miso(miso_b), .tx_data(tx_data), .tx_snap(tx_snap_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .frame_err(frame_err_b),
    .err_cnt(err_cnt_b), .busy(busy_b)
  );

  int            n_checks = 0;
  int            n_fail   = 0;
  int            ferr_a   = 0;
  int            snap_a   = 0;
  logic [7:0]    exp_miso [$];
  logic [DW-1:0] exp_rx   [$];
  logic [DW-1:0] got_rx   [$];
  logic [7:0]    mo       [16];

  always @(negedge clk) begin
    if (rx_valid_a) got_rx.push_back(rx_data_a);
    if (frame_err_a) ferr_a++;
    if (tx_snap_a) snap_a++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ssel(input int tgt, input logic v);
    if (tgt == 0) ssel_a = v;
    else ssel_b = v;
  endtask

  task automatic spi_bits(input int tgt, input logic [7:0] b,
                          input int nb, output logic [7:0] mi);
    mi = '0;
    for (int i = 7; i > 7 - nb; i--) begin
      mosi = b[i];
      wait_clk(5);
      mi[i] = (tgt == 0) ? miso_a : miso_b;
      sck = 1'b1;
      wait_clk(5);
      sck = 1'b0;
    end
  endtask

  // Expected MISO stream: tx bytes little-endian, then XOR of all of them, then zeros.
  task automatic push_miso(input logic [DW-1:0] tx, input int nbytes);
    logic [7:0] s;
    logic [7:0] b;
    s = '0;
    for (int k = 0; k < nbytes; k++) begin
      if (k < 8) begin
        b = tx[8*k +: 8];
        s = s ^ b;
        exp_miso.push_back(b);
      end else if (k == 8) begin
        exp_miso.push_back(s);
      end else begin
        exp_miso.push_back(8'h00);
      end
    end
  endtask

  task automatic set_frame(input logic [7:0] base, input logic [7:0] flip,
                           output logic [DW-1:0] rx);
    logic [7:0] s;
    s = '0;
    for (int k = 0; k < 8; k++) begin
      mo[k] = base + 8'(k);
      s = s ^ mo[k];
      rx[8*k +: 8] = mo[k];
    end
    mo[8] = s ^ flip;
    mo[9] = 8'h5A;
  endtask

  task automatic frame_body(input int tgt, input int first, input int last,
                            input bit chk);
    logic [7:0] mi, e;
    for (int k = first; k <= last; k++) begin
      spi_bits(tgt, mo[k], 8, mi);
      if (chk) begin
        n_checks++;
        if (exp_miso.size() == 0) begin
          n_fail++;
          $display("FAIL miso_byte%0d: got %h, nothing expected", k, mi);
        end else begin
          e = exp_miso.pop_front();
          if (mi !== e) begin
            n_fail++;
            $display("FAIL miso_byte%0d: got %h required %h", k, mi, e);
          end
        end
      end
      if (k == 0 && tgt == 0) begin
        n_checks++;
        if (busy_a !== 1'b1) begin
          n_fail++;
          $display("FAIL busy_in_frame: got %b required 1", busy_a);
        end
      end
    end
  endtask

  task automatic frame_close(input int tgt);
    wait_clk(5);
    set_ssel(tgt, 1'b1);
    wait_clk(12);
  endtask

  task automatic run_frame(input int tgt, input int nbytes, input int xbits,
                           input bit chk);
    logic [7:0] mi;
    set_ssel(tgt, 1'b0);
    wait_clk(6);
    frame_body(tgt, 0, nbytes - 1, chk);
    if (xbits > 0) spi_bits(tgt, 8'hFF, xbits, mi);
    frame_close(tgt);
  endtask

  task automatic check_rx(input string name);
    logic [DW-1:0] e, g;
    n_checks++;
    if (got_rx.size() != exp_rx.size()) begin
      n_fail++;
      $display("FAIL %s_count: got %0d commits required %0d",
               name, got_rx.size(), exp_rx.size());
      got_rx.delete();
      exp_rx.delete();
    end else begin
      while (exp_rx.size() > 0) begin
        e = exp_rx.pop_front();
        g = got_rx.pop_front();
        n_checks++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL %s_data: got %h required %h", name, g, e);
        end
      end
    end
  endtask

  task automatic check_val(input string name, input logic [DW-1:0] got,
                           input logic [DW-1:0] req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; sck = 1'b0; mosi = 1'b0;
    ssel_a = 1'b1; ssel_b = 1'b1; tx_data = '0;
    wait_clk(3);
    check_val("reset_rx_data", rx_data_a, '0);
    check_val("reset_flags",
              DW'({rx_valid_a, frame_err_a, busy_a, miso_a, tx_snap_a}), '0);
    check_val("reset_err_cnt_a", DW'(err_cnt_a), '0);
    check_val("reset_err_cnt_b", DW'(err_cnt_b), '0);
    rst_n = 1'b1;
    wait_clk(5);
  endtask

  task automatic test_good_frame;
    logic [DW-1:0] rx;
    int f0;
    f0 = ferr_a;
    tx_data = 64'h1122334455667788;
    set_frame(8'h01, 8'h00, rx);
    exp_rx.push_back(64'h0807060504030201);
    push_miso(tx_data, 9);
    run_frame(0, 9, 0, 1);
    check_rx("good_rx");
    check_val("good_err_cnt", DW'(err_cnt_a), 0);
    check_val("good_frame_err", DW'(ferr_a - f0), 0);
    check_val("good_busy_after", DW'(busy_a), 0);
  endtask

  task automatic test_bad_checksum;
    logic [DW-1:0] rx;
    int f0;
    f0 = ferr_a;
    set_frame(8'h01, 8'h01, rx);
    push_miso(tx_data, 9);
    run_frame(0, 9, 0, 1);
    check_rx("badsum_rx");
    check_val("badsum_rx_data_kept", rx_data_a, 64'h0807060504030201);
    check_val("badsum_err_cnt", DW'(err_cnt_a), 1);
    check_val("badsum_frame_err", DW'(ferr_a - f0), 1);
  endtask

  task automatic test_bad_length;
    logic [DW-1:0] rx;
    int f0;
    f0 = ferr_a;
    set_frame(8'h61, 8'h00, rx);
    push_miso(tx_data, 8);
    run_frame(0, 8, 0, 1);
    push_miso(tx_data, 10);
    run_frame(0, 10, 0, 1);
    push_miso(tx_data, 8);
    run_frame(0, 8, 3, 1);
    check_rx("len_rx");
    check_val("len_rx_data_kept", rx_data_a, 64'h0807060504030201);
    check_val("len_err_cnt", DW'(err_cnt_a), 4);
    check_val("len_frame_err", DW'(ferr_a - f0), 3);
  endtask

  task automatic test_snapshot;
    logic [DW-1:0] rx;
    int s0;
    s0 = snap_a;
    tx_data = 64'hCAFEBABEDEADBEEF;
    set_frame(8'h10, 8'h00, rx);
    exp_rx.push_back(rx);
    push_miso(64'hCAFEBABEDEADBEEF, 9);
    set_ssel(0, 1'b0);
    for (int i = 0; i < 10 && snap_a == s0; i++) wait_clk(1);
    n_checks++;
    if (snap_a == s0) begin
      n_fail++;
      $display("FAIL snap_seen: got no tx_snap within 10 clk required 1");
    end
    wait_clk(2);
    tx_data = 64'h0123456789ABCDEF;
    wait_clk(2);
    frame_body(0, 0, 8, 1);
    frame_close(0);
    check_rx("snap_rx");
    check_val("snap_count", DW'(snap_a - s0), 1);
  endtask

  task automatic test_reset_abort;
    logic [DW-1:0] rx;
    logic [7:0] mi;
    int f0;
    f0 = ferr_a;
    tx_data = 64'h0F1E2D3C4B5A6978;
    set_frame(8'h20, 8'h00, rx);
    set_ssel(0, 1'b0);
    wait_clk(6);
    frame_body(0, 0, 2, 0);
    spi_bits(0, mo[3], 4, mi);
    rst_n = 1'b0;
    wait_clk(2);
    check_val("abort_miso_in_reset", DW'(miso_a), 0);
    check_val("abort_busy_in_reset", DW'(busy_a), 0);
    rst_n = 1'b1;
    wait_clk(2);
    spi_bits(0, {mo[3][3:0], 4'h0}, 4, mi);
    frame_body(0, 4, 8, 0);
    frame_close(0);
    check_rx("abort_rx");
    check_val("abort_frame_err", DW'(ferr_a - f0), 0);
    check_val("abort_rx_data", rx_data_a, '0);
    set_frame(8'h30, 8'h00, rx);
    exp_rx.push_back(rx);
    push_miso(tx_data, 9);
    run_frame(0, 9, 0, 1);
    check_rx("after_abort_rx");
    check_val("after_abort_err_cnt", DW'(err_cnt_a), 0);
  endtask

  task automatic test_saturation;
    logic [DW-1:0] rx;
    set_frame(8'h40, 8'hFF, rx);
    for (int r = 1; r <= 5; r++) begin
      run_frame(1, 9, 0, 0);
      check_val($sformatf("sat_err_cnt_%0d", r), DW'(err_cnt_b),
                DW'((r < 3) ? r : 3));
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_bad_length();
    test_snapshot();
    test_reset_abort();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
